// File: rtl/shift_pkg.sv
// Shared encodings for the multi-cycle shifter: operation codes and FSM states.
package shift_pkg;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_ROL = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SHIFT = 2'b01,
    S_DONE  = 2'b10
  } state_t;

endpackage

// File: rtl/shift_unit_seq_step.sv
// Combinational shift of a WIDTH-bit value by k (0..STEP) positions for one op.
module shift_step
  import shift_pkg::*;
#(
  parameter  int WIDTH = 32,
  parameter  int STEP  = 1,
  localparam int KW    = $clog2(STEP + 1)
) (
  input  logic [WIDTH-1:0] din,
  input  logic [KW-1:0]    k,
  input  logic [1:0]       op,
  input  logic             sign,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] fill;

  always_comb begin
    // Top k bits set; used to back-fill SRA with the sign latched at accept.
    fill = ~({WIDTH{1'b1}} >> k);
    dout = din;
    case (op)
      OP_SLL:  dout = din << k;
      OP_SRL:  dout = din >> k;
      OP_SRA:  dout = (din >> k) | (sign ? fill : '0);
      OP_ROL:  dout = (din << k) | (din >> (WIDTH - int'(k)));
      default: dout = din;
    endcase
  end

endmodule

// File: rtl/shift_unit_seq.sv
// Multi-cycle shifter: accepts one operand, shifts up to STEP bits per cycle,
// returns the registered result over a valid/ready handshake.
module shift_unit_seq
  import shift_pkg::*;
#(
  parameter  int WIDTH = 32,
  parameter  int STEP  = 1,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] data_in,
  input  logic [SHW-1:0]   shamt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] data_out,
  output logic             zero
);

  localparam int             CW     = SHW + 1;
  localparam int             KW     = $clog2(STEP + 1);
  localparam logic [CW-1:0]  STEP_C = CW'(STEP);

  state_t           state, nstate;
  logic [WIDTH-1:0] work;
  logic [WIDTH-1:0] step_out;
  logic [CW-1:0]    rem;
  logic [CW-1:0]    k_c;
  logic [KW-1:0]    k;
  logic [1:0]       opr;
  logic             sgn;
  logic             last_step;

  assign k_c       = (rem < STEP_C) ? rem : STEP_C;
  assign k         = k_c[KW-1:0];
  assign last_step = (rem == k_c);

  shift_step #(
    .WIDTH (WIDTH),
    .STEP  (STEP)
  ) u_step (
    .din  (work),
    .k    (k),
    .op   (opr),
    .sign (sgn),
    .dout (step_out)
  );

  always_comb begin
    nstate    = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      S_IDLE: begin
        in_ready = rst_n;
        if (in_valid) nstate = (shamt == '0) ? S_DONE : S_SHIFT;
      end
      S_SHIFT: begin
        if (last_step) nstate = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) nstate = S_IDLE;
      end
      default: nstate = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      rem      <= '0;
      data_out <= '0;
      zero     <= 1'b1;
    end else begin
      state <= nstate;
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            rem <= {1'b0, shamt};
            if (shamt == '0) begin
              data_out <= data_in;
              zero     <= (data_in == '0);
            end
          end
        end
        S_SHIFT: begin
          rem <= rem - k_c;
          if (last_step) begin
            data_out <= step_out;
            zero     <= (step_out == '0);
          end
        end
        default: ;
      endcase
    end
  end

  // Working operand, op and sign are pure datapath and need no reset.
  always_ff @(posedge clk) begin
    if (state == S_IDLE && in_valid) begin
      work <= data_in;
      opr  <= op;
      sgn  <= data_in[WIDTH-1];
    end else if (state == S_SHIFT) begin
      work <= step_out;
    end
  end

endmodule
